// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: op codes, FSM states,
// flag bit positions and the latched operation record.
package alu_sched_pkg;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_NOT = 3'd2;
  localparam logic [2:0] FN_AND = 3'd3;
  localparam logic [2:0] FN_OR  = 3'd4;
  localparam logic [2:0] FN_XOR = 3'd5;
  localparam logic [2:0] FN_CMP = 3'd6;
  localparam logic [2:0] FN_EQ  = 3'd7;

  localparam int FLG_ZERO  = 3;
  localparam int FLG_OVF   = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OUT   = 0;

  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] func;
    logic [3:0] a;
    logic [3:0] b;
  } alu_op_t;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU; flags are {zero, overflow, carry, out}.
module alu4_core
  import alu_sched_pkg::*;
(
  input  logic [2:0] func,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic [3:0] flags
);

  logic [3:0] nb;
  logic [4:0] sum_add;
  logic [4:0] sum_sub;
  logic       ovf;
  logic       carry;
  logic       out;

  // Two's-complement negate of b, shared by sub and cmp.
  assign nb      = ~b + 4'd1;
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, nb};

  // Op decode; flags not meaningful for an op stay 0.
  always_comb begin
    result = 4'd0;
    ovf    = 1'b0;
    carry  = 1'b0;
    out    = 1'b0;
    case (func)
      FN_ADD: begin
        {carry, result} = sum_add;
        ovf = (a[3] == b[3]) && (sum_add[3] != a[3]);
      end
      FN_SUB: begin
        {carry, result} = sum_sub;
        ovf = (a[3] == nb[3]) && (sum_sub[3] != a[3]);
      end
      FN_NOT: result = ~a;
      FN_AND: result = a & b;
      FN_OR:  result = a | b;
      FN_XOR: result = a ^ b;
      FN_CMP: out = sum_sub[4];
      FN_EQ:  out = (a == b);
      default: result = 4'd0;
    endcase
  end

  // Pack flags; zero follows the result for every op.
  always_comb begin
    flags            = 4'd0;
    flags[FLG_ZERO]  = (result == 4'd0);
    flags[FLG_OVF]   = ovf;
    flags[FLG_CARRY] = carry;
    flags[FLG_OUT]   = out;
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one 4-bit ALU between NREQ requesters.
// One op in flight: IDLE grants, EXEC holds for EXEC_CYC cycles, RESP waits
// for the consumer to take the tagged result.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter  int NREQ     = 2,
  parameter  int EXEC_CYC = 1,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_func,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [3:0]        resp_result,
  output logic [3:0]        resp_flags,
  output logic [IDW-1:0]    resp_id
);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CNTW-1:0] cnt;
  alu_op_t         op;
  logic [IDW-1:0]  op_id;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  idx;
  logic            fire;
  alu_op_t         sel_op;
  logic [3:0]      alu_result;
  logic [3:0]      alu_flags;

  // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Grant is only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == ST_IDLE && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  assign fire = |req_ready;

  // Winner's operation, picked out of the flat request buses.
  always_comb begin
    sel_op      = '0;
    sel_op.func = req_func[3*int'(gnt_idx) +: 3];
    sel_op.a    = req_a[4*int'(gnt_idx) +: 4];
    sel_op.b    = req_b[4*int'(gnt_idx) +: 4];
  end

  alu4_core u_alu (
    .func   (op.func),
    .a      (op.a),
    .b      (op.b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Scheduler FSM; response registers keep their last value after handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      op          <= '0;
      op_id       <= '0;
      resp_valid  <= 1'b0;
      resp_result <= 4'd0;
      resp_flags  <= 4'd0;
      resp_id     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            op     <= sel_op;
            op_id  <= gnt_idx;
            rr_ptr <= IDW'((int'(gnt_idx) + 1) % NREQ);
            cnt    <= CNTW'(EXEC_CYC - 1);
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
            resp_id     <= op_id;
            resp_valid  <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
